cp0_regs: RTL and testbench
===========================

CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 SHALL have parameter CNT_PRESCALE, default 2, meaning CLK cycles per Count increment (legal 1..16).
REQ-002 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RESET_N  in  1  synchronous, active-low reset.
REQ-004 SHALL have port E_ENTER  in  1  exception entry strobe from exceptions unit.
REQ-005 SHALL have port ERET  in  1  exception return strobe.
REQ-006 SHALL have port CAUSE_IN  in  5  ExcCode of the entering exception.
REQ-007 SHALL have port EPC_IN  in  32  delay-slot-compensated return PC.
REQ-008 SHALL have port BD_IN  in  1  faulting instruction was in a delay slot.
REQ-009 SHALL have port HW_INT  in  6  level external interrupt lines, IP[7:2].
REQ-010 SHALL have port MTC0  in  1  write strobe.
REQ-011 SHALL have port ADDR  in  5  CP0 register number for read and write.
REQ-012 SHALL have port WDATA  in  32  write data.
REQ-013 SHALL have port RDATA  out  32  combinational read of register ADDR.
REQ-014 SHALL have port EPC_Q  out  32  current EPC, used as ERET target.
REQ-015 SHALL have port INTERRUPT  out  1  registered interrupt request to exceptions unit.
REQ-016 SHALL have port EXL  out  1  Status.EXL.

Function
REQ-017 SHALL implement Count(9), Compare(11), Status(12), Cause(13), EPC(14); other ADDR read 0, writes ignored.
REQ-018 Status SHALL hold IM[15:8], EXL[1], IE[0]; other bits read 0, not writable.
REQ-019 Cause SHALL hold BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[1:0] software-writable.
REQ-020 Cause.IP[7] SHALL read TI; IP[6:2] SHALL read HW_INT[4:0]; HW_INT[5] SHALL be ORed into IP[7].
REQ-021 Count SHALL increment by 1 every CNT_PRESCALE cycles, wrapping 0xFFFFFFFF->0.
REQ-022 TI SHALL set on the cycle Count increments to a value equal to Compare; cleared only by an MTC0 to Compare or reset.
REQ-023 MTC0 to Count SHALL load WDATA and clear the prescaler; that load SHALL NOT set TI even if equal to Compare.
REQ-024 E_ENTER SHALL set EXL and load ExcCode<=CAUSE_IN; EPC<=EPC_IN and BD<=BD_IN only if EXL was 0.
REQ-025 ERET SHALL clear EXL; E_ENTER with ERET in same cycle: E_ENTER wins, ERET ignored.
REQ-026 E_ENTER or ERET SHALL cancel a same-cycle MTC0 (write discarded); Count still advances.
REQ-027 MTC0 SHALL take effect at the next edge; RDATA in the write cycle SHALL show the old value.
REQ-028 INTERRUPT SHALL register IE & ~EXL & |(IP & IM), one-cycle latency from source change.
REQ-029 INTERRUPT SHALL be forced 0 in the cycle after E_ENTER or ERET.
REQ-030 EPC_Q SHALL equal the EPC register (no bypass of same-cycle EPC_IN).

Reset
REQ-031 With RESET_N low at an edge: Status=0x00000002, Cause=0, EPC=0, Count=0, Compare=0xFFFFFFFF, prescaler=0, INTERRUPT=0.
REQ-032 Reset SHALL override all same-cycle strobes; outputs valid at the first edge after RESET_N goes high.

Structure
REQ-033 Register numbers, Status/Cause bit positions and reset constants SHALL live in shared package cp0_pkg.
REQ-034 Count/Compare/prescaler/TI SHALL form sub-module cp0_timer; rest stays in cp0_regs.

Verification
REQ-035 Reset, MTC0 Status=0x0000FF01, HW_INT=6'b000001 -> INTERRUPT=1 one cycle after Status write lands.
REQ-036 E_ENTER with CAUSE_IN=8, EPC_IN=0x400, BD_IN=1 at EXL=0 -> EPC_Q=0x400, Cause=0x80000020, EXL=1, INTERRUPT=0.
REQ-037 Second E_ENTER (CAUSE_IN=12, EPC_IN=0x800) while EXL=1 -> EPC_Q stays 0x400, ExcCode=12; then ERET -> EXL=0.
REQ-038 CNT_PRESCALE=2, Compare=5, Count=0 -> TI=1 after 10 cycles; MTC0 Compare=0x20 -> TI=0 next cycle.
REQ-039 Same-cycle E_ENTER+ERET+MTC0 Status=0 -> EXL=1, Status IE/IM unchanged; RESET_N low mid-run -> all REQ-031 values.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions and
// reset constants used by cp0_regs and cp0_timer.
package cp0_pkg;

   typedef enum logic [4:0] {
      CP0_COUNT   = 5'd9,
      CP0_COMPARE = 5'd11,
      CP0_STATUS  = 5'd12,
      CP0_CAUSE   = 5'd13,
      CP0_EPC     = 5'd14
   } cp0_reg_e;

   localparam int unsigned ST_IE     = 0;
   localparam int unsigned ST_EXL    = 1;
   localparam int unsigned ST_IM_LO  = 8;
   localparam int unsigned ST_IM_HI  = 15;

   localparam int unsigned CA_EXC_LO = 2;
   localparam int unsigned CA_EXC_HI = 6;
   localparam int unsigned CA_IP_LO  = 8;
   localparam int unsigned CA_IP_HI  = 15;
   localparam int unsigned CA_TI     = 30;
   localparam int unsigned CA_BD     = 31;

   localparam logic [31:0] STATUS_RST  = 32'h0000_0002;
   localparam logic [31:0] CAUSE_RST   = '0;
   localparam logic [31:0] EPC_RST     = '0;
   localparam logic [31:0] COUNT_RST   = '0;
   localparam logic [31:0] COMPARE_RST = '1;

   function automatic logic [31:0] pack_status(input logic [7:0] im,
                                               input logic       exl,
                                               input logic       ie);
      logic [31:0] r;
      r                     = '0;
      r[ST_IM_HI:ST_IM_LO]  = im;
      r[ST_EXL]             = exl;
      r[ST_IE]              = ie;
      return r;
   endfunction

   function automatic logic [31:0] pack_cause(input logic       bd,
                                              input logic       ti,
                                              input logic [7:0] ip,
                                              input logic [4:0] exc);
      logic [31:0] r;
      r                       = '0;
      r[CA_BD]                = bd;
      r[CA_TI]                = ti;
      r[CA_IP_HI:CA_IP_LO]    = ip;
      r[CA_EXC_HI:CA_EXC_LO]  = exc;
      return r;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled free-running Count, Compare register
// and sticky timer-interrupt flag TI.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int unsigned CNT_PRESCALE = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic [3:0]  presc;
   logic        tick;
   logic [31:0] count_inc;

   assign tick      = (presc == 4'(CNT_PRESCALE - 1));
   assign count_inc = count + 32'd1;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         count   <= COUNT_RST;
         compare <= COMPARE_RST;
         presc   <= '0;
         ti      <= 1'b0;
      end else begin
         // A software load of Count never raises TI; only a real increment does.
         if (count_we) begin
            count <= wdata;
            presc <= '0;
         end else if (tick) begin
            presc <= '0;
            count <= count_inc;
            if (count_inc == compare)
               ti <= 1'b1;
         end else begin
            presc <= presc + 4'd1;
         end
         if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file: Status, Cause, EPC plus the Count/Compare timer,
// exception entry/return sequencing and the registered interrupt request.
module cp0_regs
   import cp0_pkg::*;
#(
   parameter int unsigned CNT_PRESCALE = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        E_ENTER,
   input  logic        ERET,
   input  logic [4:0]  CAUSE_IN,
   input  logic [31:0] EPC_IN,
   input  logic        BD_IN,
   input  logic [5:0]  HW_INT,
   input  logic        MTC0,
   input  logic [4:0]  ADDR,
   input  logic [31:0] WDATA,
   output logic [31:0] RDATA,
   output logic [31:0] EPC_Q,
   output logic        INTERRUPT,
   output logic        EXL
);

   logic [7:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [4:0]  exc;
   logic [1:0]  ip_sw;
   logic [31:0] epc;
   logic        int_q;
   logic [7:0]  ip;
   logic        wr_ok;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   assign wr_ok = MTC0 & ~E_ENTER & ~ERET;
   assign ip    = {ti | HW_INT[5], HW_INT[4:0], ip_sw};

   cp0_timer #(.CNT_PRESCALE(CNT_PRESCALE)) u_timer (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .count_we   (wr_ok && (ADDR == CP0_COUNT)),
      .compare_we (wr_ok && (ADDR == CP0_COMPARE)),
      .wdata      (WDATA),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         im    <= STATUS_RST[ST_IM_HI:ST_IM_LO];
         exl   <= STATUS_RST[ST_EXL];
         ie    <= STATUS_RST[ST_IE];
         bd    <= CAUSE_RST[CA_BD];
         exc   <= CAUSE_RST[CA_EXC_HI:CA_EXC_LO];
         ip_sw <= CAUSE_RST[CA_IP_LO+1:CA_IP_LO];
         epc   <= EPC_RST;
         int_q <= 1'b0;
      end else begin
         int_q <= ~(E_ENTER | ERET) & ie & ~exl & (|(ip & im));
         // Nested entry keeps the original EPC/BD so ERET returns to the first fault.
         if (E_ENTER) begin
            exl <= 1'b1;
            exc <= CAUSE_IN;
            if (!exl) begin
               epc <= EPC_IN;
               bd  <= BD_IN;
            end
         end else if (ERET) begin
            exl <= 1'b0;
         end else if (MTC0) begin
            case (ADDR)
               CP0_STATUS: begin
                  im  <= WDATA[ST_IM_HI:ST_IM_LO];
                  exl <= WDATA[ST_EXL];
                  ie  <= WDATA[ST_IE];
               end
               CP0_CAUSE: ip_sw <= WDATA[CA_IP_LO+1:CA_IP_LO];
               CP0_EPC:   epc   <= WDATA;
               default:   ;
            endcase
         end
      end
   end

   always_comb begin
      RDATA = '0;
      case (ADDR)
         CP0_COUNT:   RDATA = count;
         CP0_COMPARE: RDATA = compare;
         CP0_STATUS:  RDATA = pack_status(im, exl, ie);
         CP0_CAUSE:   RDATA = pack_cause(bd, ti, ip, exc);
         CP0_EPC:     RDATA = epc;
         default:     RDATA = '0;
      endcase
   end

   assign EPC_Q     = epc;
   assign INTERRUPT = int_q;
   assign EXL       = exl;

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: directed scenarios followed by random
// traffic, all checked against a behavioural CP0 model.
module tb_cp0_regs;

   localparam int unsigned P = 2;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        E_ENTER;
   logic        ERET;
   logic [4:0]  CAUSE_IN;
   logic [31:0] EPC_IN;
   logic        BD_IN;
   logic [5:0]  HW_INT;
   logic        MTC0;
   logic [4:0]  ADDR;
   logic [31:0] WDATA;
   logic [31:0] RDATA;
   logic [31:0] EPC_Q;
   logic        INTERRUPT;
   logic        EXL;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   cp0_regs #(.CNT_PRESCALE(P)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .E_ENTER   (E_ENTER),
      .ERET      (ERET),
      .CAUSE_IN  (CAUSE_IN),
      .EPC_IN    (EPC_IN),
      .BD_IN     (BD_IN),
      .HW_INT    (HW_INT),
      .MTC0      (MTC0),
      .ADDR      (ADDR),
      .WDATA     (WDATA),
      .RDATA     (RDATA),
      .EPC_Q     (EPC_Q),
      .INTERRUPT (INTERRUPT),
      .EXL       (EXL)
   );

   // Reference state, kept as plain architectural values.
   bit          m_valid = 1'b0;
   logic [7:0]  m_im;
   logic        m_exl, m_ie, m_bd, m_ti, m_int;
   logic [4:0]  m_exc;
   logic [1:0]  m_ipsw;
   logic [31:0] m_epc, m_count, m_compare;
   int          m_div;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      logic [7:0] ipv;
      ipv = {m_ti | HW_INT[5], HW_INT[4:0], m_ipsw};
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return (32'(m_im) << 8) + (m_exl ? 32'd2 : 32'd0) + (m_ie ? 32'd1 : 32'd0);
         5'd13:   return (m_bd ? 32'h8000_0000 : 32'd0) + (m_ti ? 32'h4000_0000 : 32'd0)
                         + (32'(ipv) << 8) + (32'(m_exc) << 2);
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      logic [7:0] ipv;
      bit         wr;
      if (!RESET_N) begin
         m_im = 8'd0; m_exl = 1'b1; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
         m_exc = 5'd0; m_ipsw = 2'd0; m_epc = 32'd0; m_count = 32'd0;
         m_compare = 32'hFFFF_FFFF; m_div = 0; m_int = 1'b0;
         m_valid = 1'b1;
         return;
      end
      ipv   = {m_ti | HW_INT[5], HW_INT[4:0], m_ipsw};
      m_int = !(E_ENTER || ERET) && m_ie && !m_exl && ((ipv & m_im) != 8'd0);
      wr    = MTC0 && !E_ENTER && !ERET;
      if (wr && ADDR == 5'd9) begin
         m_count = WDATA;
         m_div   = 0;
      end else begin
         m_div = m_div + 1;
         if (m_div == int'(P)) begin
            m_div   = 0;
            m_count = m_count + 32'd1;
            if (m_count == m_compare) m_ti = 1'b1;
         end
      end
      if (wr && ADDR == 5'd11) begin
         m_compare = WDATA;
         m_ti      = 1'b0;
      end
      if (E_ENTER) begin
         if (!m_exl) begin
            m_epc = EPC_IN;
            m_bd  = BD_IN;
         end
         m_exl = 1'b1;
         m_exc = CAUSE_IN;
      end else if (ERET) begin
         m_exl = 1'b0;
      end else if (wr) begin
         if (ADDR == 5'd12) begin
            m_im = WDATA[15:8]; m_exl = WDATA[1]; m_ie = WDATA[0];
         end else if (ADDR == 5'd13) begin
            m_ipsw = WDATA[9:8];
         end else if (ADDR == 5'd14) begin
            m_epc = WDATA;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check combinational read before the edge, advance one clock, check outputs.
   task automatic step(input string tag);
      #1;
      if (m_valid) chk({tag, "_rdata"}, RDATA, m_read(ADDR));
      @(posedge CLK);
      model_edge();
      #1;
      if (m_valid) begin
         chk({tag, "_epc_q"}, EPC_Q, m_epc);
         chk({tag, "_exl"}, 32'(EXL), 32'(m_exl));
         chk({tag, "_int"}, 32'(INTERRUPT), 32'(m_int));
      end
   endtask

   task automatic idle();
      E_ENTER = 1'b0; ERET = 1'b0; MTC0 = 1'b0;
   endtask

   initial begin
      RESET_N = 1'b0; E_ENTER = 1'b0; ERET = 1'b0; MTC0 = 1'b0; ADDR = 5'd0;
      WDATA = '0; CAUSE_IN = '0; EPC_IN = '0; BD_IN = 1'b0; HW_INT = '0;

      // Reset values, including strobes asserted under reset
      step("rst0");
      E_ENTER = 1'b1; ERET = 1'b1; MTC0 = 1'b1; ADDR = 5'd12; WDATA = 32'hFFFF_FFFF;
      step("rst1");
      idle();
      chk("rst_status", RDATA, 32'h0000_0002);
      chk("rst_exl", 32'(EXL), 32'd1);
      chk("rst_int", 32'(INTERRUPT), 32'd0);
      chk("rst_epc", EPC_Q, 32'd0);
      ADDR = 5'd11; step("rst2"); chk("rst_compare", RDATA, 32'hFFFF_FFFF);
      ADDR = 5'd9;  step("rst3"); chk("rst_count", RDATA, 32'd0);
      ADDR = 5'd13; step("rst4"); chk("rst_cause", RDATA, 32'd0);
      ADDR = 5'd3;  step("rst5"); chk("rst_unimpl", RDATA, 32'd0);

      // Status write enables IP2; interrupt one cycle after it lands
      RESET_N = 1'b1; MTC0 = 1'b1; ADDR = 5'd12; WDATA = 32'h0000_FF01; HW_INT = 6'b000001;
      step("s35w");
      idle();
      chk("req35_lat", 32'(INTERRUPT), 32'd0);
      step("s35a");
      chk("req35_int", 32'(INTERRUPT), 32'd1);

      // First exception entry
      HW_INT = '0; E_ENTER = 1'b1; CAUSE_IN = 5'd8; EPC_IN = 32'h400; BD_IN = 1'b1; ADDR = 5'd13;
      step("s36");
      idle();
      chk("req36_epc", EPC_Q, 32'h400);
      chk("req36_exl", 32'(EXL), 32'd1);
      chk("req36_int", 32'(INTERRUPT), 32'd0);
      chk("req36_cause", RDATA, 32'h8000_0020);

      // Nested entry keeps EPC, updates ExcCode; then ERET
      E_ENTER = 1'b1; CAUSE_IN = 5'd12; EPC_IN = 32'h800; BD_IN = 1'b0;
      step("s37");
      idle();
      chk("req37_epc", EPC_Q, 32'h400);
      chk("req37_cause", RDATA, 32'h8000_0030);
      ERET = 1'b1;
      step("s37r");
      idle();
      chk("req37_exl", 32'(EXL), 32'd0);

      // Compare match after 10 cycles, cleared by Compare write
      MTC0 = 1'b1; ADDR = 5'd11; WDATA = 32'd5; step("s38c");
      ADDR = 5'd9; WDATA = 32'd0; step("s38n");
      idle(); ADDR = 5'd13;
      repeat (9) step("s38w");
      chk("req38_ti_early", 32'(RDATA[30]), 32'd0);
      step("s38t");
      chk("req38_ti_set", 32'(RDATA[30]), 32'd1);
      MTC0 = 1'b1; ADDR = 5'd11; WDATA = 32'h20; step("s38x");
      idle(); ADDR = 5'd13; #1;
      chk("req38_ti_clr", 32'(RDATA[30]), 32'd0);

      // Triple strobe: entry wins, MTC0 Status discarded
      E_ENTER = 1'b1; ERET = 1'b1; MTC0 = 1'b1; ADDR = 5'd12; WDATA = 32'd0;
      CAUSE_IN = 5'd4; EPC_IN = 32'h1234; BD_IN = 1'b0;
      step("s39");
      idle();
      chk("req39_exl", 32'(EXL), 32'd1);
      chk("req39_status", RDATA, 32'h0000_FF03);

      // Mid-run reset
      RESET_N = 1'b0;
      step("s39r");
      chk("mid_rst_exl", 32'(EXL), 32'd1);
      chk("mid_rst_int", 32'(INTERRUPT), 32'd0);
      chk("mid_rst_epc", EPC_Q, 32'd0);
      chk("mid_rst_status", RDATA, 32'h0000_0002);
      ADDR = 5'd9;  step("s39a"); chk("mid_rst_count", RDATA, 32'd0);
      ADDR = 5'd11; step("s39b"); chk("mid_rst_compare", RDATA, 32'hFFFF_FFFF);
      ADDR = 5'd13; step("s39c"); chk("mid_rst_cause", RDATA, 32'd0);
      RESET_N = 1'b1;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         RESET_N  = ($urandom_range(0, 299) != 0);
         E_ENTER  = ($urandom_range(0, 24) == 0);
         ERET     = ($urandom_range(0, 19) == 0);
         MTC0     = ($urandom_range(0, 3) == 0);
         CAUSE_IN = 5'($urandom);
         EPC_IN   = $urandom;
         BD_IN    = 1'($urandom);
         if ($urandom_range(0, 9) == 0) HW_INT = 6'($urandom);
         case ($urandom_range(0, 6))
            0: ADDR = 5'd9;
            1: ADDR = 5'd11;
            2: ADDR = 5'd12;
            3: ADDR = 5'd13;
            4: ADDR = 5'd14;
            default: ADDR = 5'($urandom);
         endcase
         WDATA = $urandom;
         if (ADDR == 5'd11) WDATA = m_count + 32'($urandom_range(0, 6));
         if (ADDR == 5'd9 && $urandom_range(0, 3) == 0)
            WDATA = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         step("rnd");
      end

      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
